// File: rtl/mog_pkg.sv
// mog_pkg: shared constants, state enum and sd packing for the MoG write-back path.
// The sd floor is enabled by defining MOG_WB_SD_FLOOR_EN.
package mog_pkg;

    localparam int K_DEF = 3;
    localparam int WORD_W = 48;
    localparam logic [15:0] SD_FLOOR = 16'h0400;

    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_e;

    function automatic logic [15:0] sd_pack(input logic [15:0] sd);
`ifdef MOG_WB_SD_FLOOR_EN
        return (sd < SD_FLOOR) ? SD_FLOOR : sd;
`else
        return sd;
`endif
    endfunction

endpackage

// File: rtl/mog_sync_fifo.sv
// mog_sync_fifo: single-clock FIFO; a write while full is taken only if a pop happens in the same cycle.
module mog_sync_fifo #(
    parameter int W = 50,
    parameter int DEPTH = 32,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    output logic [W-1:0]  rd_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0] count_q, count_d;
    logic wr_ok, rd_ok;

    assign full = count_q == (AW+1)'(DEPTH);
    assign empty = count_q == '0;
    assign count = count_q;
    assign rd_data = mem_q[rd_ptr_q];
    assign rd_ok = rd_en && !empty;
    assign wr_ok = wr_en && (!full || rd_ok);

    always_comb begin
        wr_ptr_d = wr_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = rd_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d = count_q + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/gauss_param_wb.sv
// gauss_param_wb: packs updated Gaussian parameters into 48-bit words and streams them out with frame tags.
// Define MOG_WB_SD_FLOOR_EN to clamp the packed sd field to a minimum.
module gauss_param_wb
    import mog_pkg::*;
#(
    parameter int K = K_DEF,
    parameter int PIX_PER_FRAME = 76800,
    parameter int FIFO_DEPTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              in_valid,
    input  logic [31:0]       mean_in,
    input  logic [31:0]       sd_in,
    input  logic [31:0]       w_in,
    output logic [WORD_W-1:0] m_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic              m_tlast,
    output logic              m_tuser,
    output logic              overflow,
    output logic              frame_done
);

    localparam int IW = (K > 1) ? $clog2(K) : 1;
    localparam int PW = (PIX_PER_FRAME > 1) ? $clog2(PIX_PER_FRAME) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int FW = WORD_W + 2;

    state_e state_q, state_d;
    logic v1_q, v1_d;
    logic [15:0] mean1_q, mean1_d, sd1_q, sd1_d, w1_q, w1_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [PW-1:0] pix_q, pix_d;
    logic ovf_q, ovf_d;
    logic first, last, idx_wrap, pix_wrap, pop, full, empty;
    logic [CW-1:0] count;
    logic [FW-1:0] wr_data, rd_data;

    assign idx_wrap = idx_q == IW'(K - 1);
    assign pix_wrap = pix_q == PW'(PIX_PER_FRAME - 1);
    assign first = (idx_q == '0) && (pix_q == '0);
    assign last = idx_wrap && pix_wrap;
    assign wr_data = {last, first, mean1_q, sd_pack(sd1_q), w1_q};
    assign m_tvalid = count != '0;
    assign {m_tlast, m_tuser, m_tdata} = empty ? '0 : rd_data;
    assign pop = m_tvalid && m_tready;
    assign frame_done = pop && m_tlast;
    assign overflow = ovf_q;

    // Counters advance on every write attempt, dropped or not, so tags stay aligned to pixel positions.
    always_comb begin
        v1_d = in_valid && (state_q == ACTIVE);
        mean1_d = mean_in[31:16];
        sd1_d = sd_in[31:16];
        w1_d = w_in[31:16];
        state_d = (v1_q && last) ? DONE : state_q;
        idx_d = v1_q ? (idx_wrap ? '0 : idx_q + 1'b1) : idx_q;
        pix_d = (v1_q && idx_wrap) ? (pix_wrap ? '0 : pix_q + 1'b1) : pix_q;
        ovf_d = ovf_q || (v1_q && full && !pop);
        if (frame_start) begin
            state_d = ACTIVE;
            idx_d = '0;
            pix_d = '0;
            ovf_d = (state_q == ACTIVE) ? 1'b0 : ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            v1_q <= 1'b0;
            mean1_q <= '0;
            sd1_q <= '0;
            w1_q <= '0;
            idx_q <= '0;
            pix_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            state_q <= state_d;
            v1_q <= v1_d;
            mean1_q <= mean1_d;
            sd1_q <= sd1_d;
            w1_q <= w1_d;
            idx_q <= idx_d;
            pix_q <= pix_d;
            ovf_q <= ovf_d;
        end
    end

    mog_sync_fifo #(.W(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (v1_q),
        .wr_data (wr_data),
        .rd_en   (pop),
        .rd_data (rd_data),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

endmodule

// File: tb/tb_gauss_param_wb.sv
// tb_gauss_param_wb: directed scoreboard bench for gauss_param_wb with K=3, PIX_PER_FRAME=4, FIFO_DEPTH=32.
module tb_gauss_param_wb;

    logic clk = 1'b0;
    logic rst, frame_start, in_valid, m_tready;
    logic [31:0] mean_in, sd_in, w_in;
    logic [47:0] m_tdata;
    logic m_tvalid, m_tlast, m_tuser, overflow, frame_done;

    logic [49:0] q[$];
    int checks = 0;
    int errors = 0;
    int seq = 0;
    int midx = 0;
    int mpix = 0;
    bit mdone = 1'b1;

    always #5 clk = ~clk;

    gauss_param_wb #(.K(3), .PIX_PER_FRAME(4), .FIFO_DEPTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .in_valid    (in_valid),
        .mean_in     (mean_in),
        .sd_in       (sd_in),
        .w_in        (w_in),
        .m_tdata     (m_tdata),
        .m_tvalid    (m_tvalid),
        .m_tready    (m_tready),
        .m_tlast     (m_tlast),
        .m_tuser     (m_tuser),
        .overflow    (overflow),
        .frame_done  (frame_done)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        in_valid = 1'b0;
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
        midx = 0;
        mpix = 0;
        mdone = 1'b0;
    endtask

    task automatic send_sd(input bit keep, input logic [31:0] sd);
        logic [15:0] sv, sf;
        logic u, l;
        sv = 16'(seq);
        seq++;
        mean_in = {16'h1000 + sv, 16'hA5A5};
        sd_in = sd;
        w_in = {16'h3000 + sv, 16'h5A5A};
        sf = sd[31:16];
`ifdef MOG_WB_SD_FLOOR_EN
        sf = (sf < 16'h0400) ? 16'h0400 : sf;
`endif
        u = (midx == 0) && (mpix == 0);
        l = (midx == 2) && (mpix == 3);
        if (keep) q.push_back({l, u, mean_in[31:16], sf, w_in[31:16]});
        if (midx == 2) begin
            midx = 0;
            mpix = (mpix == 3) ? 0 : mpix + 1;
        end else midx++;
        mdone = l;
        in_valid = 1'b1;
        cyc();
    endtask

    task automatic send(input bit keep);
        send_sd(keep, {16'h2000 + 16'(seq), 16'h1234});
    endtask

    task automatic burst(input int n, input int keep_n);
        for (int i = 0; i < n; i++) begin
            if (mdone) begin
                in_valid = 1'b0;
                repeat (2) cyc();
                frame();
            end
            send(i < keep_n);
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        m_tready = 1'b1;
        for (int i = 0; i < 300 && q.size() != 0; i++) cyc();
        chk("drain_remaining", 64'(q.size()), 64'd0);
        repeat (2) cyc();
        chk("empty_after_drain", 64'(m_tvalid), 64'd0);
    endtask

    always @(negedge clk) begin
        logic [49:0] e;
        if (!rst) begin
            if (m_tvalid && m_tready) begin
                chk("word_expected", 64'(q.size() != 0), 64'd1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk("word", {13'd0, m_tlast, m_tuser, m_tdata, frame_done}, {13'd0, e, e[49]});
                end
            end else chk("frame_done_idle", 64'(frame_done), 64'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        frame_start = 1'b0;
        in_valid = 1'b0;
        m_tready = 1'b0;
        mean_in = '0;
        sd_in = '0;
        w_in = '0;
        repeat (3) cyc();
        chk("rst_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst_tdata", 64'(m_tdata), 64'd0);
        chk("rst_tags", {62'd0, m_tlast, m_tuser}, 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        rst = 1'b0;
        cyc();

        // one full frame, streaming, with latency check
        m_tready = 1'b1;
        frame();
        for (int i = 0; i < 12; i++) begin
            send(1'b1);
            if (i == 0) chk("latency_c1", 64'(m_tvalid), 64'd0);
            if (i == 1) chk("latency_c2", 64'(m_tvalid), 64'd1);
        end
        in_valid = 1'b0;
        repeat (2) cyc();
        in_valid = 1'b1;
        repeat (2) cyc();
        in_valid = 1'b0;
        drain();

        // full FIFO with a same-cycle pop accepts the write
        m_tready = 1'b0;
        burst(32, 32);
        repeat (2) cyc();
        chk("full_valid", 64'(m_tvalid), 64'd1);
        send(1'b1);
        in_valid = 1'b0;
        m_tready = 1'b1;
        cyc();
        m_tready = 1'b0;
        chk("full_pop_ovf", 64'(overflow), 64'd0);
        drain();
        chk("full_pop_ovf_after", 64'(overflow), 64'd0);

        // overflow under stalled output
        m_tready = 1'b0;
        frame();
        burst(40, 32);
        repeat (2) cyc();
        chk("ovf_set", 64'(overflow), 64'd1);
        chk("ovf_valid", 64'(m_tvalid), 64'd1);
        drain();
        chk("ovf_sticky", 64'(overflow), 64'd1);

        // mid-frame restart
        m_tready = 1'b0;
        burst(5, 5);
        repeat (2) cyc();
        chk("ovf_before_restart", 64'(overflow), 64'd1);
        frame();
        chk("ovf_cleared", 64'(overflow), 64'd0);
        send(1'b1);
        in_valid = 1'b0;
        drain();

        // small sd value
        send_sd(1'b1, 32'h0200_0000);
        in_valid = 1'b0;
        drain();

        // reset with words buffered
        m_tready = 1'b0;
        burst(10, 10);
        repeat (2) cyc();
        chk("buffered_valid", 64'(m_tvalid), 64'd1);
        rst = 1'b1;
        cyc();
        chk("rst_mid_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst_mid_tdata", 64'(m_tdata), 64'd0);
        q.delete();
        rst = 1'b0;
        mdone = 1'b1;
        m_tready = 1'b1;
        in_valid = 1'b1;
        repeat (3) cyc();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("idle_ignored", 64'(m_tvalid), 64'd0);
        end
        frame();
        send(1'b1);
        send(1'b1);
        in_valid = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gauss_param_wb.md
GAUSS_PARAM_WB -- requirements
Module: gauss_param_wb

Interface
REQ-001 SHALL have parameter K, default 3: Gaussians per pixel.
REQ-002 SHALL have parameter PIX_PER_FRAME, default 76800: pixels per frame.
REQ-003 SHALL have parameter FIFO_DEPTH, default 32, power of two: output buffer entries.
REQ-004 SHALL have port clk, input, 1: sole clock, all logic on rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous active-high reset.
REQ-006 SHALL have port frame_start, input, 1: one-cycle pulse arming a new frame.
REQ-007 SHALL have port in_valid, input, 1: updated parameter set present; no backpressure to the update pipeline.
REQ-008 SHALL have ports mean_in, sd_in and w_in, input, 32 each: updated mean, sd and weight.
REQ-009 SHALL have port m_tdata, output, 48: packed {mean[31:16], sd[31:16], w[31:16]}.
REQ-010 SHALL have ports m_tvalid, output, 1 and m_tready, input, 1: output handshake.
REQ-011 SHALL have ports m_tlast, output, 1 (last Gaussian of last pixel) and m_tuser, output, 1 (first word of frame).
REQ-012 SHALL have ports overflow, output, 1 (sticky drop flag) and frame_done, output, 1 (one-cycle pulse).

Function
REQ-013 SHALL implement states IDLE, ACTIVE and DONE: IDLE->ACTIVE on frame_start; ACTIVE->DONE when word PIX_PER_FRAME*K-1 is written; DONE->ACTIVE on frame_start.
REQ-014 SHALL ignore in_valid in IDLE and DONE.
REQ-015 SHALL register inputs for one cycle, then write the packed word to the FIFO on the next cycle.
REQ-016 SHALL raise m_tvalid on the edge following the FIFO write when the FIFO was empty, giving 2-cycle latency from in_valid.
REQ-017 SHALL pop one word on each cycle with m_tvalid && m_tready, and hold m_tdata, m_tlast and m_tuser stable while m_tvalid && !m_tready.
REQ-018 SHALL use a write-side Gaussian index (0..K-1, wrap) and pixel counter (0..PIX_PER_FRAME-1) to compute tuser (index 0, pixel 0) and tlast (index K-1, pixel PIX_PER_FRAME-1), storing both in the FIFO with data.
REQ-019 SHALL drop the write when the FIFO is full with no simultaneous pop, set overflow, and still advance the counters.
REQ-020 SHALL accept the write when the FIFO is full and a pop occurs in the same cycle, leaving occupancy unchanged.
REQ-021 SHALL pulse frame_done for one cycle on the pop of the m_tlast word.
REQ-022 SHALL, on frame_start in ACTIVE (mid-frame), zero the counters, clear overflow, keep FIFO contents and remain ACTIVE.
REQ-023 SHALL size the occupancy count to log2(FIFO_DEPTH)+1 bits, with pointers wrapping modulo FIFO_DEPTH.

Reset
REQ-024 SHALL, on rst, set state to IDLE, empty the FIFO, zero the counters, and force m_tvalid, m_tlast, m_tuser, overflow, frame_done and m_tdata to 0.
REQ-025 SHALL let rst take priority over frame_start and in_valid in the same cycle.

Configuration
REQ-026 SHALL, with MOG_WB_SD_FLOOR_EN defined, replace packed sd fields below 16'h0400 with 16'h0400 before the FIFO write.
REQ-027 SHALL, without MOG_WB_SD_FLOOR_EN, pack sd[31:16] unmodified with no added latency in either case.

Structure
REQ-028 SHALL take K default, the 48-bit word width, the SD_FLOOR constant and the state enum from shared package mog_pkg.
REQ-029 SHALL use a single sub-module mog_sync_fifo (single clock, synchronous reset, full/empty/count outputs) for buffering.

Verification
REQ-030 SHALL cover: K=3, PIX_PER_FRAME=4, frame_start then 12 in_valid with m_tready=1 -> 12 words in order; m_tuser on word 0; m_tlast and frame_done on word 11; first m_tvalid 2 cycles after first in_valid.
REQ-031 SHALL cover: m_tready=0 for 40 cycles while 40 words arrive, FIFO_DEPTH=32 -> overflow=1, first 32 words delivered, m_tlast still on word index 11 mod 12 positions.
REQ-032 SHALL cover: FIFO full, in_valid and pop in the same cycle -> word accepted, overflow stays 0.
REQ-033 SHALL cover: sd_in=32'h0200_0000 -> sd field 16'h0400 with MOG_WB_SD_FLOOR_EN, 16'h0200 without.
REQ-034 SHALL cover: frame_start after 5 words -> next word carries m_tuser=1, overflow cleared, earlier 5 words still delivered.
REQ-035 SHALL cover: rst asserted while 10 words are buffered -> m_tvalid=0 next cycle; in_valid ignored until frame_start.
